to_sw_mailbox: RTL and testbench

Buffers a stream of 15-bit result words from the hardware pipeline and presents them one at a time to software through the 16-bit `to_sw` PIO input port. It sits directly upstream of that PIO: its `to_sw_port` output drives the PIO `in_port`. Software's 1-bit acknowledge arrives from the `from_sw` PIO output. A toggle-based handshake lets the Nios II poll without losing or duplicating words.

---
 rtl/to_sw_mailbox.sv | 154 +++++++++++++++
 tb/tb_to_sw_mailbox.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/to_sw_mailbox.sv
// to_sw_mailbox
//
// Buffers 15-bit result words from the hardware pipeline and hands them to
// software one at a time through a 16-bit PIO input port. Bit 15 of the
// presented word is a sequence toggle. Software acknowledges a word by
// writing that toggle value back on sw_ack.
//
// Optional feature macro: TO_SW_MBOX_LOSSY_EN
//   When defined, in_ready is tied high. Pushes that find the FIFO full are
//   dropped and counted on drop_cnt, which saturates at 255.
//   When undefined, in_ready gives lossless backpressure.
//
// Parameters
//   DEPTH      FIFO depth in words (power of two, 2..64)
//   AW         log2(DEPTH)
// Ports
//   clk        system clock (shared with the PIO)
//   reset_n    asynchronous active-low reset
//   in_data    pipeline data word
//   in_valid   in_data valid this cycle
//   in_ready   block can accept a word (registered)
//   sw_ack     software acknowledge toggle (from_sw bit 0)
//   to_sw_port {seq, data} presented to software (registered)
//   drop_cnt   dropped-word count (lossy build only)

module to_sw_mailbox #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sw_ack,
`ifdef TO_SW_MBOX_LOSSY_EN
   output logic [7:0]  drop_cnt,
`endif
   output logic [15:0] to_sw_port
);

   typedef enum logic {
      StIdle    = 1'b0,
      StPresent = 1'b1
   } state_e;

   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [14:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ack_q;
   logic          seq;
   logic          empty, full;
   logic          push, pop;

   // The sequence toggle lives in the presented word itself.
   assign seq   = to_sw_port[15];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CntFull);

   // Presentation FSM
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StPresent;
            end
         end
         StPresent: begin
            // Only an ack matching the current toggle completes the word.
            if (ack_q == seq) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef TO_SW_MBOX_LOSSY_EN
   logic drop;

   // A same-cycle pop frees the slot the push needs.
   assign push     = in_valid & (~full | pop);
   assign drop     = in_valid & full & ~pop;
   assign in_ready = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= 8'd0;
      end else if (drop && (drop_cnt != 8'hff)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   logic in_ready_q;

   assign push     = in_valid & in_ready_q;
   assign in_ready = in_ready_q;

   // Uses next-state occupancy so the filling push deasserts ready on its own edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (cnt_d != CntFull);
      end
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Storage carries no reset; contents are meaningless once cnt is cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         to_sw_port <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Same clock domain as the PIO, so a single register suffices.
         ack_q   <= sw_ack;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            to_sw_port <= {~seq, mem[rd_ptr_q]};
         end
      end
   end

endmodule

// File: tb/tb_to_sw_mailbox.sv
module tb_to_sw_mailbox;

`ifdef TO_SW_MBOX_LOSSY_EN
   localparam bit Lossy = 1'b1;
`else
   localparam bit Lossy = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        sw_ack;
   logic [15:0] to_sw_port;
`ifdef TO_SW_MBOX_LOSSY_EN
   logic [7:0]  drop_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Scoreboard of expected presented words, in presentation order.
   logic [15:0] sb[$];
   logic        sb_seq;

   to_sw_mailbox #(.DEPTH(8), .AW(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sw_ack     (sw_ack),
`ifdef TO_SW_MBOX_LOSSY_EN
      .drop_cnt   (drop_cnt),
`endif
      .to_sw_port (to_sw_port)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one word across one edge; accepted words go to the scoreboard.
   task automatic push_word(input logic [14:0] d, input bit accept);
      in_valid = 1'b1;
      in_data  = d;
      if (accept) begin
         sb_seq = ~sb_seq;
         sb.push_back({sb_seq, d});
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for a new word, compare with scoreboard, then acknowledge.
   task automatic consume(input string tag);
      logic [15:0] exp;
      int n = 0;
      while ((to_sw_port[15] === sw_ack) && (n < 20)) begin
         tick();
         n++;
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, to_sw_port);
      end else begin
         exp = sb.pop_front();
         check(tag, 32'(to_sw_port), 32'(exp));
         sw_ack = exp[15];
      end
   endtask

   initial begin
      logic [15:0] exp;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      sw_ack   = 1'b0;
      sb_seq   = 1'b0;

      // Reset
      repeat (3) tick();
      check("rst_port", 32'(to_sw_port), 32'h0000);
      check("rst_ready", 32'(in_ready), 32'(Lossy));
      reset_n = 1'b1;
      tick();
      check("rst_release_ready", 32'(in_ready), 32'h1);

      // Single word: push at edge k, presented after edge k+1
      push_word(15'h1234, 1'b1);
      check("single_pre", 32'(to_sw_port), 32'h0000);
      tick();
      exp = sb.pop_front();
      check("single_present", 32'(to_sw_port), 32'(exp));
      check("single_value", 32'(to_sw_port), 32'h9234);
      sw_ack = 1'b1;
      tick();
      tick();
      check("single_idle", 32'(dut.state_q), 32'h0);
      check("single_hold", 32'(to_sw_port), 32'h9234);

      // Burst of 9: first 8 leave 7 buffered, the 9th fills the FIFO
      for (int i = 1; i <= 9; i++) begin
         push_word(15'(i), 1'b1);
         if (i == 8) begin
            check("burst8_cnt", 32'(dut.cnt_q), 32'd7);
            check("burst8_ready", 32'(in_ready), 32'h1);
         end
      end
      check("burst9_cnt", 32'(dut.cnt_q), 32'd8);
      check("burst9_ready", 32'(in_ready), 32'(Lossy));
      check("burst_head", 32'(to_sw_port), 32'h0001);
      for (int i = 1; i <= 9; i++) begin
         consume($sformatf("burst_w%0d", i));
      end
      repeat (3) tick();
      check("burst_drained", 32'(dut.cnt_q), 32'd0);

      // Wrong ack: sw_ack left at the old toggle value
      push_word(15'h0abc, 1'b1);
      tick();
      check("wrong_ack_first", 32'(to_sw_port), 32'(sb[0]));
      repeat (20) tick();
      check("wrong_ack_port", 32'(to_sw_port), 32'(sb[0]));
      check("wrong_ack_state", 32'(dut.state_q), 32'h1);
      consume("wrong_ack_consume");
      repeat (3) tick();

      // Mid-transfer reset with 3 buffered words
      for (int i = 0; i < 4; i++) begin
         push_word(15'h0100 + 15'(i), 1'b1);
      end
      check("mid_cnt", 32'(dut.cnt_q), 32'd3);
      check("mid_state", 32'(dut.state_q), 32'h1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
      check("mid_rst_port", 32'(to_sw_port), 32'h0000);
      check("mid_rst_state", 32'(dut.state_q), 32'h0);
      check("mid_rst_ready", 32'(in_ready), 32'(Lossy));
      sb.delete();
      sb_seq = 1'b0;
      sw_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("mid_release_ready", 32'(in_ready), 32'h1);
      push_word(15'h0005, 1'b1);
      tick();
      check("mid_new_value", 32'(to_sw_port), 32'h8005);
      consume("mid_new_word");
      repeat (3) tick();

`ifdef TO_SW_MBOX_LOSSY_EN
      // Lossy: 10 pushes, 1 presented, 8 buffered, 1 dropped
      for (int i = 0; i < 10; i++) begin
         push_word(15'h0200 + 15'(i), i < 9);
      end
      check("lossy_drop", 32'(drop_cnt), 32'd1);
      check("lossy_ready", 32'(in_ready), 32'h1);
      check("lossy_cnt", 32'(dut.cnt_q), 32'd8);
      check("lossy_head", 32'(to_sw_port), 32'(sb[0]));
      for (int i = 0; i < 9; i++) begin
         consume($sformatf("lossy_w%0d", i));
      end
      repeat (3) tick();
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
